chacha20_block_core: RTL
========================

// Module: chacha20_block_core
// PURPOSE
//  Iterative ChaCha20 block function: builds the 16-word initial state from key/nonce/counter,
//  applies one chacha20_column_and_diagonal_round per cycle for DOUBLE_ROUNDS cycles, then adds
//  the initial state to produce one 512-bit keystream block. Feeds the keystream/XOR stage of
//  the RNG and cipher datapath; the round module is instantiated once and reused every cycle.
// PARAMETERS
//  DOUBLE_ROUNDS  10  double rounds per block (10 = ChaCha20; 4/6 allowed for ChaCha8/12); range 1..15
// PORTS
//  clock        in   1    single clock, all state on rising edge
//  clear        in   1    synchronous reset, active-high
//  start        in   1    request a block; accepted when start & start_ready
//  start_ready  out  1    high only in IDLE
//  key          in   256  key, little-endian bytes; key[32*i+31:32*i] -> state word 4+i
//  nonce        in   96   nonce, little-endian; nonce[32*i+31:32*i] -> state word 13+i
//  counter      in   32   block counter -> state word 12
//  out_valid    out  1    keystream block valid
//  out_ready    in   1    downstream accepts block when out_valid & out_ready
//  out_block    out  512  keystream; state word i at [32*i+31:32*i]
// BEHAVIOUR
//  - Reset (clear=1 at a rising edge): state IDLE, start_ready=1, out_valid=0, out_block=0,
//    round counter=0, working/initial state registers=0. clear wins over every other input,
//    including mid-ROUND and DONE; any in-flight block is discarded, no output produced.
//  - Constant words 0..3: 0x61707865 0x3320646e 0x79622d32 0x6b206574.
//  - FSM IDLE -> ROUND -> ADD -> DONE -> IDLE:
//    IDLE : start_ready=1. On start: initial<=assembled state, working<=assembled state,
//           rnd<=0, go ROUND. key/nonce/counter sampled only on the accept cycle.
//    ROUND: working<=round(working), rnd<=rnd+1; after DOUBLE_ROUNDS cycles (rnd==DOUBLE_ROUNDS-1) go ADD.
//    ADD  : out_block[i]<=working[i]+initial[i] per 32-bit word, mod 2^32, no carry between words; go DONE.
//    DONE : out_valid=1, out_block stable; on out_ready go IDLE (out_valid=0 next cycle).
//  - Latency: start accepted at edge T -> out_valid high from cycle T+DOUBLE_ROUNDS+2
//    (12 cycles at default). Throughput 1 block per DOUBLE_ROUNDS+3 cycles with out_ready held high.
//  - start_ready=0 in ROUND/ADD/DONE; start there is ignored, not queued.
//  - out_valid must not drop, and out_block must not change, until handshake completes.
//  - out_block retains last value after handshake (only meaningful while out_valid=1).
//  - counter is used as given; no internal increment, no wrap detection (0xFFFFFFFF is legal).
//  - rnd is 4 bits; no path lets it exceed DOUBLE_ROUNDS-1.
// TESTING
//  1 RFC 7539 2.3.2: key bytes 00..1f (key[31:0]=0x03020100), nonce words 0x09000000,0x4a000000,0,
//    counter 1 -> after 12 cycles out_block words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3,
//    word 15 = 4e3c50a2; all 16 words match RFC.
//  2 Back-pressure: vector 1 with out_ready=0 for 20 cycles -> out_valid stays 1, out_block
//    constant, start_ready 0; out_ready=1 one cycle -> IDLE, start_ready=1 next cycle.
//  3 start pulsed during ROUND with different key -> ignored; result still equals vector 1.
//  4 clear asserted at round 5 -> next cycle IDLE, out_valid=0, out_block=0; new start with
//    vector 1 yields correct block at normal latency.
//  5 Back-to-back: out_ready=1, start held high, counters 1 then 2 -> two blocks, each matching
//    software model, spaced 13 cycles; counter=0xFFFFFFFF and all-zero key/nonce also checked against model.
//  6 DOUBLE_ROUNDS=4 build: random key/nonce/counter vs ChaCha8 model, latency 6 cycles.

Source files
------------

// File: rtl/chacha20_block_core.sv
// Iterative ChaCha20 block function: one column+diagonal double round per clock,
// then a feed-forward add of the initial state yields a 512-bit keystream block.
`timescale 1ns/1ps

module chacha20_column_and_diagonal_round (
  input  logic [511:0] state_in,
  output logic [511:0] state_out
);

  logic [31:0] w_p0 [16];
  logic [31:0] col_p0 [16];
  logic [31:0] diag_p0 [16];

  function automatic logic [127:0] quarter(
    input logic [31:0] a_in,
    input logic [31:0] b_in,
    input logic [31:0] c_in,
    input logic [31:0] d_in
  );
    logic [31:0] a, b, c, d;
    a = a_in + b_in;  d = d_in ^ a;  d = {d[15:0], d[31:16]};
    c = c_in + d;     b = b_in ^ c;  b = {b[19:0], b[31:20]};
    a = a + b;        d = d ^ a;     d = {d[23:0], d[31:24]};
    c = c + d;        b = b ^ c;     b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_p0[i] = state_in[32*i +: 32];
    end
    // column round
    {col_p0[0], col_p0[4], col_p0[8],  col_p0[12]} = quarter(w_p0[0], w_p0[4], w_p0[8],  w_p0[12]);
    {col_p0[1], col_p0[5], col_p0[9],  col_p0[13]} = quarter(w_p0[1], w_p0[5], w_p0[9],  w_p0[13]);
    {col_p0[2], col_p0[6], col_p0[10], col_p0[14]} = quarter(w_p0[2], w_p0[6], w_p0[10], w_p0[14]);
    {col_p0[3], col_p0[7], col_p0[11], col_p0[15]} = quarter(w_p0[3], w_p0[7], w_p0[11], w_p0[15]);
    // diagonal round
    {diag_p0[0], diag_p0[5], diag_p0[10], diag_p0[15]} = quarter(col_p0[0], col_p0[5], col_p0[10], col_p0[15]);
    {diag_p0[1], diag_p0[6], diag_p0[11], diag_p0[12]} = quarter(col_p0[1], col_p0[6], col_p0[11], col_p0[12]);
    {diag_p0[2], diag_p0[7], diag_p0[8],  diag_p0[13]} = quarter(col_p0[2], col_p0[7], col_p0[8],  col_p0[13]);
    {diag_p0[3], diag_p0[4], diag_p0[9],  diag_p0[14]} = quarter(col_p0[3], col_p0[4], col_p0[9],  col_p0[14]);
    for (int i = 0; i < 16; i++) begin
      state_out[32*i +: 32] = diag_p0[i];
    end
  end

endmodule

module chacha20_block_core #(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         start,
  output logic         start_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_block
);

  typedef enum logic [1:0] {IDLE, ROUND, ADD, DONE} state_t;

  localparam logic [3:0] LAST_RND = 4'(DOUBLE_ROUNDS - 1);

  state_t       state, state_next;
  logic [3:0]   rnd;
  logic [511:0] working;
  logic [511:0] init_state;
  logic [511:0] assembled;
  logic [511:0] round_out;
  logic         accept;

  // Word-wise mod 2^32 add; carries never cross a 32-bit boundary.
  function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] s;
    for (int i = 0; i < 16; i++) begin
      s[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return s;
  endfunction

  assign assembled = {nonce, counter, key,
                      32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  assign accept    = start && (state == IDLE);

  chacha20_column_and_diagonal_round u_round (
    .state_in  (working),
    .state_out (round_out)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)           state_next = ROUND;
      ROUND:   if (rnd == LAST_RND) state_next = ADD;
      ADD:                          state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state == IDLE);
    out_valid   = (state == DONE);
  end

  // Round counter wraps to 0 on the last round so it never exceeds LAST_RND.
  always_ff @(posedge clock) begin
    if (clear) begin
      rnd        <= '0;
      working    <= '0;
      init_state <= '0;
      out_block  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            init_state <= assembled;
            working    <= assembled;
            rnd        <= '0;
          end
        end
        ROUND: begin
          working <= round_out;
          rnd     <= (rnd == LAST_RND) ? 4'd0 : rnd + 4'd1;
        end
        ADD: begin
          out_block <= add_words(working, init_state);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
